regfile_param: RTL and testbench
================================

// Module: regfile_param
// PURPOSE
//  Parametrised multi-read register file: next generation of the TinyTapeout 8x4 register file.
//  Width, depth and register-0 policy are generalised.
//  Adds a sequenced bulk-clear engine with busy/done handshake, a write-reject flag and optional
//  write-to-read forwarding. Sits behind the tt_um pin wrapper; the wrapper maps ui_in/uio_in onto these ports.
// PARAMETERS
//  WIDTH     4  data bits per entry (1..32)
//  DEPTH     8  number of entries (2..64, need not be a power of 2)
//  ZERO_REG  1  1: entry 0 reads 0 and ignores writes; 0: entry 0 is ordinary storage
//  AW        derived = clog2(DEPTH); localparam, not overridable
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      synchronous reset, active low
//  rd_addr1  in   AW     read port 1 address
//  rd_data1  out  WIDTH  read port 1 data (combinational)
//  rd_addr2  in   AW     read port 2 address
//  rd_data2  out  WIDTH  read port 2 data (combinational)
//  wr_en     in   1      write request
//  wr_addr   in   AW     write address
//  wr_data   in   WIDTH  write data
//  clr_req   in   1      start bulk clear (sampled at the clock edge)
//  busy      out  1      clear engine active (CLEAR state)
//  clr_done  out  1      single-cycle pulse: clear finished
//  wr_drop   out  1      registered: write request of previous cycle was rejected
// BEHAVIOUR
//  Reset: one clock, synchronous, active low (rst_n=0 at a rising edge).
//   - All entries are set to 0.
//   - State becomes IDLE.
//   - busy, clr_done and wr_drop are set to 0.
//   - Reset has priority over every other input, including mid-clear: the clear aborts, the array is all-zero.
//  Read: asynchronous.
//   - rd_dataN = entry[rd_addrN].
//   - Address >= DEPTH reads 0.
//   - Address 0 reads 0 when ZERO_REG=1.
//  Write: synchronous, 1-cycle latency; data is visible on reads the cycle after the edge.
//   A write is accepted when wr_en=1, state is IDLE and wr_addr < DEPTH.
//   - Address 0 with ZERO_REG=1: silently ignored, wr_drop stays 0.
//   - wr_en=1 in CLEAR or DONE, or with wr_addr >= DEPTH: not written; wr_drop=1 on the next cycle.
//  Clear FSM:
//   - IDLE: clr_req=1 -> CLEAR; the index is loaded with 0.
//   - CLEAR: entry[idx] <= 0 and idx++ each cycle; busy=1. After entry DEPTH-1 -> DONE.
//   - DONE: clr_done=1 for exactly one cycle, then -> IDLE.
//   - A full clear takes DEPTH cycles in CLEAR, plus 1 cycle in DONE.
//   - clr_req in CLEAR or DONE is ignored; it is not queued.
//   - clr_req and wr_en in the same IDLE cycle: the write is accepted at that edge, and the clear starts at the same edge.
//   - During CLEAR, reads return the current contents: entries already cleared read 0, entries not yet reached keep their old value.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//   - If a write is accepted this cycle and rd_addrN == wr_addr, rd_dataN = wr_data in the same cycle (write-first).
//   - Forwarding never applies to entry 0 when ZERO_REG=1.
//   - Forwarding never applies to a rejected write.
//  REGFILE_BYPASS_EN undefined:
//   - Reads return the stored value; new data appears the cycle after the edge (read-before-write).
// STRUCTURE
//  Package regfile_pkg:
//   - clr_state_t enum {IDLE, CLEAR, DONE}.
//   - clog2 function.
//   - Reset-value constant RF_RESET_VAL = 0.
//  Sub-module regfile_clear_fsm: owns the state, idx, busy and clr_done.
//   It outputs clr_we and clr_idx to the array.
//  Top level owns the array, write acceptance, wr_drop, read muxes and the bypass.
// TESTING
//  1. rst_n=0 for 1 cycle, then read all addresses -> all 0; busy=0, clr_done=0, wr_drop=0.
//  2. Write 4'hA to addr 3 -> rd_data1 = 4'hA from the next cycle.
//     Write to addr 0 -> rd 0 returns 0 (ZERO_REG=1), wr_drop=0.
//  3. Fill addrs 1..7 with 4'h1..4'h7, then pulse clr_req.
//     -> busy=1 for exactly 8 cycles; addr k reads 0 from CLEAR cycle k+1; then clr_done=1 for 1 cycle; then all 0.
//  4. wr_en=1 to addr 5 during CLEAR -> wr_drop=1 the next cycle; addr 5 reads 0 after clr_done.
//     With DEPTH=6, a write to addr 7 -> wr_drop=1.
//  5. rst_n=0 at CLEAR cycle 3 -> next cycle busy=0, clr_done never pulses, all entries read 0.
//  6. With REGFILE_BYPASS_EN: write 4'h9 to addr 2 while rd_addr2=2 -> rd_data2=4'h9 in the same cycle.
//     Without the macro -> old value that cycle, 4'h9 the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file and its clear engine.
`timescale 1ns/1ps
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  localparam logic RF_RESET_VAL = 1'b0;

  // Ceiling log2, used for address widths at elaboration time.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'sd1 << result) < value) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: walks every entry once, then pulses done for one cycle.
`timescale 1ns/1ps
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr_req,
  output logic          o_busy,
  output logic          o_clr_done,
  output logic          o_idle,
  output logic          o_clr_we,
  output logic [AW-1:0] o_clr_idx
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  clr_state_t    r_state;
  clr_state_t    w_state_nxt;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_nxt;

  // State and index registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= {AW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state logic; clr_req outside IDLE is dropped, not queued.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = CLEAR;
          w_idx_nxt   = {AW{1'b0}};
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CLEAR: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = DONE;
          w_idx_nxt   = {AW{1'b0}};
        end else begin
          w_idx_nxt   = r_idx + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = {AW{1'b0}};
      end
    endcase
  end

  // Outputs are pure decodes of the state register.
  always_comb begin
    o_busy     = 1'b0;
    o_clr_done = 1'b0;
    o_idle     = 1'b0;
    case (r_state)
      IDLE:    o_idle     = 1'b1;
      CLEAR:   o_busy     = 1'b1;
      DONE:    o_clr_done = 1'b1;
      default: o_idle     = 1'b0;
    endcase
    o_clr_we  = o_busy;
    o_clr_idx = r_idx;
  end

endmodule

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with bulk-clear engine and write-reject flag.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
`timescale 1ns/1ps
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 1,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data2,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_req,
  output logic             busy,
  output logic             clr_done,
  output logic             wr_drop
);

  localparam logic [AW:0]      DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [WIDTH-1:0] RST_WORD = {WIDTH{RF_RESET_VAL}};

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W);
  endfunction

  function automatic logic is_zero_slot(input logic [AW-1:0] a);
    return (ZERO_REG != 32'sd0) && (a == {AW{1'b0}});
  endfunction

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_wr_drop;
  logic             w_idle;
  logic             w_clr_we;
  logic [AW-1:0]    w_clr_idx;
  logic             w_wr_valid;
  logic             w_wr_acc;
  logic             w_wr_rej;

  regfile_clear_fsm #(
    .DEPTH (DEPTH)
  ) u_clear_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr_req  (clr_req),
    .o_busy     (busy),
    .o_clr_done (clr_done),
    .o_idle     (w_idle),
    .o_clr_we   (w_clr_we),
    .o_clr_idx  (w_clr_idx)
  );

  // Write acceptance: a zero-slot write is valid but stores nothing and is not flagged.
  always_comb begin
    w_wr_valid = wr_en && w_idle && in_range(wr_addr);
    w_wr_acc   = w_wr_valid && !is_zero_slot(wr_addr);
    w_wr_rej   = wr_en && !w_wr_valid;
  end

  // Storage array; clear and user writes are mutually exclusive by FSM state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= RST_WORD;
      end
    end else if (w_clr_we) begin
      r_mem[w_clr_idx] <= RST_WORD;
    end else if (w_wr_acc) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Reject flag reports the previous cycle's write request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= w_wr_rej;
    end
  end

  assign wr_drop = r_wr_drop;

  // Read port 1 mux.
  always_comb begin
    rd_data1 = RST_WORD;
    if (in_range(rd_addr1) && !is_zero_slot(rd_addr1)) begin
`ifdef REGFILE_BYPASS_EN
      if (w_wr_acc && (rd_addr1 == wr_addr)) begin
        rd_data1 = wr_data;
      end else begin
        rd_data1 = r_mem[rd_addr1];
      end
`else
      rd_data1 = r_mem[rd_addr1];
`endif
    end else begin
      rd_data1 = RST_WORD;
    end
  end

  // Read port 2 mux.
  always_comb begin
    rd_data2 = RST_WORD;
    if (in_range(rd_addr2) && !is_zero_slot(rd_addr2)) begin
`ifdef REGFILE_BYPASS_EN
      if (w_wr_acc && (rd_addr2 == wr_addr)) begin
        rd_data2 = wr_data;
      end else begin
        rd_data2 = r_mem[rd_addr2];
      end
`else
      rd_data2 = r_mem[rd_addr2];
`endif
    end else begin
      rd_data2 = RST_WORD;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench: two instances (DEPTH=8/ZERO_REG=1 and DEPTH=6/ZERO_REG=0) against a behavioural model.
`timescale 1ns/1ps
module tb_regfile_param;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      rd_addr1, rd_addr2, wr_addr;
  logic [3:0]      wr_data;
  logic            wr_en, clr_req;
  logic [1:0][3:0] rd1, rd2;
  logic [1:0]      busy, done, drop;

  always #10 clk = ~clk;

  regfile_param #(.WIDTH(4), .DEPTH(8), .ZERO_REG(1)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_data1(rd1[0]),
    .rd_addr2(rd_addr2), .rd_data2(rd2[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .busy(busy[0]), .clr_done(done[0]), .wr_drop(drop[0])
  );

  regfile_param #(.WIDTH(4), .DEPTH(6), .ZERO_REG(0)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_data1(rd1[1]),
    .rd_addr2(rd_addr2), .rd_data2(rd2[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .busy(busy[1]), .clr_done(done[1]), .wr_drop(drop[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Reference model: contents per instance plus position of the clear sweep
  // (-1 = idle, 0..D-1 = entry being cleared this cycle, D = done cycle).
  logic [3:0] m_mem [2][8];
  int         m_pos [2];
  logic       m_drop[2];

  function automatic int dep(input int i);
    return (i == 0) ? 8 : 6;
  endfunction

  function automatic bit zr(input int i);
    return (i == 0);
  endfunction

  function automatic logic [3:0] m_read(input int i, input logic [2:0] a);
    if (int'(a) >= dep(i)) return 4'h0;
    if (zr(i) && a == 3'd0) return 4'h0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && m_pos[i] < 0 && wr_addr == a) return wr_data;
`endif
    return m_mem[i][a];
  endfunction

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        for (int k = 0; k < 8; k++) m_mem[i][k] = 4'h0;
        m_pos[i]  = -1;
        m_drop[i] = 1'b0;
      end else begin
        bit idle;
        idle = (m_pos[i] < 0);
        m_drop[i] = wr_en && (!idle || int'(wr_addr) >= dep(i));
        if (wr_en && idle && int'(wr_addr) < dep(i) && !(zr(i) && wr_addr == 3'd0))
          m_mem[i][wr_addr] = wr_data;
        if (m_pos[i] >= 0 && m_pos[i] < dep(i)) begin
          m_mem[i][m_pos[i]] = 4'h0;
          m_pos[i] = m_pos[i] + 1;
        end else if (m_pos[i] == dep(i)) begin
          m_pos[i] = -1;
        end else if (clr_req) begin
          m_pos[i] = 0;
        end
      end
    end
  endtask

  task automatic check_outputs(input bit sweep);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("busy%0d", i), busy[i], (m_pos[i] >= 0 && m_pos[i] < dep(i)));
      chk($sformatf("done%0d", i), done[i], (m_pos[i] == dep(i)));
      chk($sformatf("drop%0d", i), drop[i], m_drop[i]);
    end
    if (sweep) begin
      for (int a = 0; a < 8; a++) begin
        rd_addr1 = 3'(a);
        rd_addr2 = 3'(7 - a);
        #1;
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("sw_rd1_%0d_a%0d", i, a), rd1[i], m_read(i, rd_addr1));
          chk($sformatf("sw_rd2_%0d_a%0d", i, a), rd2[i], m_read(i, rd_addr2));
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rd1_%0d", i), rd1[i], m_read(i, rd_addr1));
        chk($sformatf("rd2_%0d", i), rd2[i], m_read(i, rd_addr2));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step(input bit sweep);
    @(negedge clk);
    check_outputs(sweep);
    tick();
  endtask

  initial begin
    int nbusy8, nbusy6, ndone8;
    rst_n = 1'b0; wr_en = 1'b0; clr_req = 1'b0;
    wr_addr = 3'd0; wr_data = 4'h0; rd_addr1 = 3'd0; rd_addr2 = 3'd0;
    tick();
    rst_n = 1'b1;
    step(1'b1);

    // Basic write, then zero-register write.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'hA; rd_addr1 = 3'd3; rd_addr2 = 3'd0;
    step(1'b0);
    wr_en = 1'b0;
    chk("wr3_next", rd1[0], 32'hA);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h5; rd_addr1 = 3'd0;
    step(1'b0);
    wr_en = 1'b0;
    chk("zr_rd0", rd1[0], 32'h0);
    chk("zr_drop", drop[0], 32'h0);
    chk("d6_rd0", rd1[1], 32'h5);

    // Fill, then full clear with a rejected write mid-sweep.
    for (int k = 1; k < 8; k++) begin
      wr_en = 1'b1; wr_addr = 3'(k); wr_data = 4'(k);
      step(1'b0);
    end
    wr_en = 1'b0; clr_req = 1'b1;
    step(1'b0);
    clr_req = 1'b0;
    nbusy8 = 0; nbusy6 = 0; ndone8 = 0;
    for (int c = 0; c < 12; c++) begin
      nbusy8 += int'(busy[0]);
      nbusy6 += int'(busy[1]);
      ndone8 += int'(done[0]);
      if (c == 2) begin
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 4'hF;
      end else begin
        wr_en = 1'b0;
      end
      step(1'b1);
      if (c == 2) chk("drop_in_clear", drop[0], 32'h1);
    end
    chk("clr_busy8", nbusy8, 32'd8);
    chk("clr_busy6", nbusy6, 32'd6);
    chk("clr_done8", ndone8, 32'd1);
    rd_addr1 = 3'd5; #1;
    chk("a5_after", rd1[0], 32'h0);

    // Out-of-range write on the DEPTH=6 instance only.
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 4'h3;
    step(1'b0);
    wr_en = 1'b0;
    chk("d6_drop7", drop[1], 32'h1);
    chk("d8_drop7", drop[0], 32'h0);
    step(1'b1);

    // Reset during CLEAR cycle 3 aborts the sweep and zeroes everything.
    clr_req = 1'b1;
    step(1'b0);
    clr_req = 1'b0;
    for (int c = 0; c < 3; c++) step(1'b0);
    rst_n = 1'b0;
    step(1'b0);
    rst_n = 1'b1;
    chk("rst_busy", busy[0], 32'h0);
    ndone8 = 0;
    for (int c = 0; c < 10; c++) begin
      ndone8 += int'(done[0]);
      step(1'b1);
    end
    chk("rst_nodone", ndone8, 32'd0);

    // Same-cycle read of a write in progress.
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'h4; rd_addr2 = 3'd2;
    step(1'b0);
    wr_data = 4'h9; #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_same", rd2[0], 32'h9);
`else
    chk("byp_same", rd2[0], 32'h4);
`endif
    step(1'b0);
    wr_en = 1'b0;
    chk("byp_next", rd2[0], 32'h9);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = 3'($urandom_range(0, 7));
      wr_data  = 4'($urandom_range(0, 15));
      clr_req  = ($urandom_range(0, 19) == 0);
      rd_addr1 = 3'($urandom_range(0, 7));
      rd_addr2 = 3'($urandom_range(0, 7));
      step((n % 25) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
